// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding memory execution unit.
// Accepts one load/store entry, performs one data-memory transaction,
// then broadcasts completion (and load data) on the CDB.
module load_store_unit #(
    parameter int NUM_REGS = 64,
    parameter int ROB_SIZE = 32,
    localparam int PW = $clog2(NUM_REGS),
    localparam int RW = $clog2(ROB_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [6:0]    issue_opcode,
    input  logic [2:0]    issue_funct3,
    input  logic [31:0]   issue_imm,
    input  logic [31:0]   issue_rs1_data,
    input  logic [31:0]   issue_rs2_data,
    input  logic [PW-1:0] issue_phys_rd,
    input  logic [RW-1:0] issue_rob_index,
    output logic [31:0]   dmem_addr,
    output logic [3:0]    dmem_rmask,
    output logic [3:0]    dmem_wmask,
    output logic [31:0]   dmem_wdata,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_resp,
    output logic          cdb_valid,
    output logic          cdb_rd_we,
    output logic [PW-1:0] cdb_phys_rd,
    output logic [RW-1:0] cdb_rob_index,
    output logic [31:0]   cdb_data
);

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic          r_drop;
    logic          r_is_load;
    logic [2:0]    r_funct3;
    logic [1:0]    r_lane;
    logic [3:0]    r_mask;
    logic [PW-1:0] r_phys_rd;
    logic [RW-1:0] r_rob_index;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_cdb_valid;
    logic          r_cdb_rd_we;
    logic [PW-1:0] r_cdb_phys_rd;
    logic [RW-1:0] r_cdb_rob_index;
    logic [31:0]   r_cdb_data;

    logic [31:0]   w_addr;
    logic [1:0]    w_lane;
    logic [3:0]    w_mask;
    logic [31:0]   w_wdata;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load_data;

    assign w_addr  = issue_rs1_data + issue_imm;
    assign w_lane  = w_addr[1:0];
    assign w_wdata = issue_rs2_data << {w_lane, 3'b000};

    // Byte-enable lanes for the incoming entry, derived from access size.
    always_comb begin
        w_mask = 4'b1111;
        case (issue_funct3[1:0])
            2'b00:   w_mask = 4'b0001 << w_lane;
            2'b01:   w_mask = 4'b0011 << w_lane;
            default: w_mask = 4'b1111;
        endcase
    end

    // Extract and extend the addressed byte/half from the returned word.
    always_comb begin
        w_shifted   = dmem_rdata >> {r_lane, 3'b000};
        w_load_data = w_shifted;
        case (r_funct3[1:0])
            2'b00:   w_load_data = r_funct3[2] ? {24'h0, w_shifted[7:0]}
                                               : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = r_funct3[2] ? {16'h0, w_shifted[15:0]}
                                               : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // Sequencer: accept, request, wait for response, broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_ready         <= 1'b1;
            r_drop          <= 1'b0;
            r_is_load       <= 1'b0;
            r_funct3        <= '0;
            r_lane          <= '0;
            r_mask          <= '0;
            r_phys_rd       <= '0;
            r_rob_index     <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_cdb_valid     <= 1'b0;
            r_cdb_rd_we     <= 1'b0;
            r_cdb_phys_rd   <= '0;
            r_cdb_rob_index <= '0;
            r_cdb_data      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_drop  <= 1'b0;
                    r_ready <= 1'b1;
                    if (issue_valid && !flush) begin
                        r_is_load   <= (issue_opcode == OP_LOAD);
                        r_funct3    <= issue_funct3;
                        r_lane      <= w_lane;
                        r_mask      <= w_mask;
                        r_phys_rd   <= issue_phys_rd;
                        r_rob_index <= issue_rob_index;
                        r_addr      <= {w_addr[31:2], 2'b00};
                        r_wdata     <= w_wdata;
                        r_ready     <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_resp) begin
                        if (r_drop || flush) begin
                            r_drop  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cdb_valid     <= 1'b1;
                            r_cdb_rd_we     <= r_is_load && (r_phys_rd != '0);
                            r_cdb_phys_rd   <= r_phys_rd;
                            r_cdb_rob_index <= r_rob_index;
                            r_cdb_data      <= r_is_load ? w_load_data : 32'h0;
                            r_state         <= S_DONE;
                        end
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_cdb_valid <= 1'b0;
                    r_cdb_rd_we <= 1'b0;
                    r_drop      <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A flush arriving in REQ or DONE must suppress that cycle's request or
    // completion, so the stored masks/valid are gated by the live flush.
    assign dmem_rmask    = (r_state == S_REQ && !flush &&  r_is_load) ? r_mask : '0;
    assign dmem_wmask    = (r_state == S_REQ && !flush && !r_is_load) ? r_mask : '0;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign issue_ready   = r_ready;
    assign cdb_valid     = r_cdb_valid && !flush;
    assign cdb_rd_we     = r_cdb_rd_we && !flush;
    assign cdb_phys_rd   = r_cdb_phys_rd;
    assign cdb_rob_index = r_cdb_rob_index;
    assign cdb_data      = r_cdb_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: vector table plus directed flush/reset
// sequences, with a variable-latency memory responder.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic [31:0] issue_imm;
    logic [31:0] issue_rs1_data;
    logic [31:0] issue_rs2_data;
    logic [5:0]  issue_phys_rd;
    logic [4:0]  issue_rob_index;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        cdb_valid;
    logic        cdb_rd_we;
    logic [5:0]  cdb_phys_rd;
    logic [4:0]  cdb_rob_index;
    logic [31:0] cdb_data;

    load_store_unit #(.NUM_REGS(64), .ROB_SIZE(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
        .issue_imm(issue_imm), .issue_rs1_data(issue_rs1_data),
        .issue_rs2_data(issue_rs2_data), .issue_phys_rd(issue_phys_rd),
        .issue_rob_index(issue_rob_index),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .cdb_valid(cdb_valid), .cdb_rd_we(cdb_rd_we), .cdb_phys_rd(cdb_phys_rd),
        .cdb_rob_index(cdb_rob_index), .cdb_data(cdb_data)
    );

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [5:0]  prd;
        logic [4:0]  rob;
        int          lat;
        logic [31:0] e_addr;
        logic [3:0]  e_rm;
        logic [3:0]  e_wm;
        logic [31:0] e_wd;
        logic        e_we;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        logic        we;
        logic [5:0]  prd;
        logic [4:0]  rob;
        logic [31:0] data;
    } cdb_t;

    vec_t  vecs[10];
    req_t  req_q[$];
    cdb_t  cdb_q[$];
    int    acc_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    mem_lat = 1;
    logic [31:0] mem_rdata = '0;
    logic  stray = 1'b0;
    int    resp_count = 0;
    int    cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: answers each request mask after mem_lat cycles.
    initial begin
        dmem_resp  = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_resp  = 1'b0;
            dmem_rdata = mem_rdata;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        dmem_resp = 1'b1;
                        resp_count++;
                    end
                end
                if (stray) begin
                    dmem_resp = 1'b1;
                    stray = 1'b0;
                end
                if (dmem_rmask != 4'h0 || dmem_wmask != 4'h0) cnt = mem_lat;
            end
        end
    end

    // Observer: records requests, CDB pulses and accepts mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (dmem_rmask != 4'h0 || dmem_wmask != 4'h0)
                req_q.push_back('{dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata});
            if (cdb_valid)
                cdb_q.push_back('{cdb_rd_we, cdb_phys_rd, cdb_rob_index, cdb_data});
            if (issue_valid && issue_ready && !flush)
                acc_q.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input vec_t v);
        issue_opcode    = v.op;
        issue_funct3    = v.f3;
        issue_rs1_data  = v.rs1;
        issue_imm       = v.imm;
        issue_rs2_data  = v.rs2;
        issue_phys_rd   = v.prd;
        issue_rob_index = v.rob;
        mem_lat         = v.lat;
        mem_rdata       = v.rdata;
    endtask

    // Present one entry for a single accepting cycle; returns in the REQ cycle.
    task automatic do_issue(input vec_t v);
        int t;
        drive_entry(v);
        t = 0;
        while (!issue_ready && t < 20) begin
            step();
            t++;
        end
        chk("ready_before_issue", {31'h0, issue_ready}, 32'h1);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'h0, issue_ready}, 32'h1);
        chk({tag, "_rmask"}, {28'h0, dmem_rmask}, 32'h0);
        chk({tag, "_wmask"}, {28'h0, dmem_wmask}, 32'h0);
        chk({tag, "_addr"}, dmem_addr, 32'h0);
        chk({tag, "_wdata"}, dmem_wdata, 32'h0);
        chk({tag, "_cdb_valid"}, {31'h0, cdb_valid}, 32'h0);
        chk({tag, "_cdb_we"}, {31'h0, cdb_rd_we}, 32'h0);
        chk({tag, "_cdb_prd"}, {26'h0, cdb_phys_rd}, 32'h0);
        chk({tag, "_cdb_rob"}, {27'h0, cdb_rob_index}, 32'h0);
        chk({tag, "_cdb_data"}, cdb_data, 32'h0);
    endtask

    task automatic run_vec(input int i);
        int nr, nc, t;
        string p;
        vec_t v;
        v  = vecs[i];
        p  = $sformatf("v%0d", i);
        nr = req_q.size();
        nc = cdb_q.size();
        do_issue(v);
        t = 0;
        while (cdb_q.size() == nc && t < 30) begin
            step();
            t++;
        end
        chk({p, "_cdb_seen"}, cdb_q.size(), nc + 1);
        chk({p, "_req_count"}, req_q.size(), nr + 1);
        if (req_q.size() > nr) begin
            chk({p, "_addr"}, req_q[nr].addr, v.e_addr);
            chk({p, "_rmask"}, {28'h0, req_q[nr].rm}, {28'h0, v.e_rm});
            chk({p, "_wmask"}, {28'h0, req_q[nr].wm}, {28'h0, v.e_wm});
            if (v.e_wm != 4'h0) chk({p, "_wdata"}, req_q[nr].wd, v.e_wd);
        end
        if (cdb_q.size() > nc) begin
            chk({p, "_rd_we"}, {31'h0, cdb_q[nc].we}, {31'h0, v.e_we});
            chk({p, "_data"}, cdb_q[nc].data, v.e_data);
            chk({p, "_prd"}, {26'h0, cdb_q[nc].prd}, {26'h0, v.prd});
            chk({p, "_rob"}, {27'h0, cdb_q[nc].rob}, {27'h0, v.rob});
        end
        chk({p, "_ready_after"}, {31'h0, issue_ready}, 32'h1);
        chk({p, "_valid_after"}, {31'h0, cdb_valid}, 32'h0);
    endtask

    initial begin
        vec_t b;
        int   nr, nc, nrsp, t, k;
        logic prev_ready, acc;

        //             op  f3      rs1           imm           rs2           rdata         prd rob lat e_addr        rm    wm    wd            we   data
        vecs[0] = '{LD, 3'b010, 32'h0000_1000, 32'h0000_0004, 32'h0,        32'hDEAD_BEEF, 5,  3, 1, 32'h0000_1004, 4'hF, 4'h0, 32'h0,        1'b1, 32'hDEAD_BEEF};
        vecs[1] = '{LD, 3'b000, 32'h0000_2003, 32'h0000_0000, 32'h0,        32'h80FF_FFFF, 7,  4, 1, 32'h0000_2000, 4'h8, 4'h0, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[2] = '{LD, 3'b100, 32'h0000_2003, 32'h0000_0000, 32'h0,        32'h80FF_FFFF, 7,  5, 2, 32'h0000_2000, 4'h8, 4'h0, 32'h0,        1'b1, 32'h0000_0080};
        vecs[3] = '{ST, 3'b001, 32'h0000_3000, 32'h0000_0002, 32'h1234_ABCD, 32'h0,        9,  6, 1, 32'h0000_3000, 4'h0, 4'hC, 32'hABCD_0000, 1'b0, 32'h0};
        vecs[4] = '{LD, 3'b010, 32'h0000_0040, 32'h0000_0010, 32'h0,        32'h1234_5678, 0,  7, 1, 32'h0000_0050, 4'hF, 4'h0, 32'h0,        1'b0, 32'h1234_5678};
        vecs[5] = '{LD, 3'b001, 32'h0000_0104, 32'hFFFF_FFFE, 32'h0,        32'h8001_7FFF, 12, 8, 2, 32'h0000_0100, 4'hC, 4'h0, 32'h0,        1'b1, 32'hFFFF_8001};
        vecs[6] = '{LD, 3'b101, 32'h0000_0200, 32'h0000_0000, 32'h0,        32'h1234_F00D, 13, 9, 1, 32'h0000_0200, 4'h3, 4'h0, 32'h0,        1'b1, 32'h0000_F00D};
        vecs[7] = '{ST, 3'b000, 32'h0000_0500, 32'h0000_0001, 32'h0000_00A5, 32'h0,        14, 10, 1, 32'h0000_0500, 4'h0, 4'h2, 32'h0000_A500, 1'b0, 32'h0};
        vecs[8] = '{ST, 3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,        15, 11, 3, 32'h0000_0004, 4'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[9] = '{LD, 3'b000, 32'h0000_0602, 32'h0000_0000, 32'h0,        32'h117F_2233, 16, 12, 2, 32'h0000_0600, 4'h4, 4'h0, 32'h0,        1'b1, 32'h0000_007F};

        rst = 1'b1;
        flush = 1'b0;
        issue_valid = 1'b0;
        drive_entry(vecs[0]);
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) run_vec(i);

        // Flush in IDLE alongside valid: nothing accepted.
        nr = req_q.size();
        drive_entry(vecs[0]);
        issue_valid = 1'b1;
        flush = 1'b1;
        step();
        issue_valid = 1'b0;
        flush = 1'b0;
        chk("idle_flush_ready", {31'h0, issue_ready}, 32'h1);
        step(); step(); step();
        chk("idle_flush_no_req", req_q.size(), nr);

        // Flush in REQ: no mask ever reaches memory.
        nr = req_q.size();
        nc = cdb_q.size();
        do_issue(vecs[0]);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("req_flush_ready", {31'h0, issue_ready}, 32'h1);
        step(); step(); step(); step();
        chk("req_flush_no_req", req_q.size(), nr);
        chk("req_flush_no_cdb", cdb_q.size(), nc);

        // Flush twice in WAIT with a 3-cycle memory: response consumed silently.
        b = vecs[0];
        b.lat = 3;
        nr = req_q.size();
        nc = cdb_q.size();
        do_issue(b);
        step();
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        prev_ready = 1'b1;
        t = 0;
        while (!dmem_resp && t < 20) begin
            prev_ready = issue_ready;
            step();
            t++;
        end
        chk("wait_flush_resp_seen", {31'h0, dmem_resp}, 32'h1);
        chk("wait_flush_ready_during", {31'h0, prev_ready}, 32'h0);
        chk("wait_flush_ready_after", {31'h0, issue_ready}, 32'h1);
        step(); step(); step();
        chk("wait_flush_req_count", req_q.size(), nr + 1);
        chk("wait_flush_no_cdb", cdb_q.size(), nc);

        // Flush in DONE: the completion pulse is suppressed.
        nc = cdb_q.size();
        do_issue(vecs[6]);
        t = 0;
        while (!dmem_resp && t < 20) begin
            step();
            t++;
        end
        chk("done_flush_resp_seen", {31'h0, dmem_resp}, 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("done_flush_ready", {31'h0, issue_ready}, 32'h1);
        step(); step();
        chk("done_flush_no_cdb", cdb_q.size(), nc);

        // Stray response while idle is ignored.
        nc = cdb_q.size();
        stray = 1'b1;
        step(); step(); step(); step();
        chk("stray_no_cdb", cdb_q.size(), nc);
        chk("stray_ready", {31'h0, issue_ready}, 32'h1);

        // Back-to-back: valid held high across three entries.
        nc = cdb_q.size();
        k = acc_q.size();
        b = '{LD, 3'b100, 32'h0000_0800, 32'h0, 32'h0, 32'h4433_2211, 10, 1, 1,
              32'h0, 4'h0, 4'h0, 32'h0, 1'b1, 32'h0};
        drive_entry(b);
        issue_valid = 1'b1;
        t = 0;
        for (int n = 0; n < 3 && t < 60; t++) begin
            @(negedge clk);
            acc = issue_ready;
            step();
            if (acc) begin
                n++;
                if (n < 3) begin
                    b.rs1 = 32'h0000_0800 + n;
                    b.prd = 6'(10 + n);
                    b.rob = 5'(1 + n);
                    drive_entry(b);
                end else begin
                    issue_valid = 1'b0;
                end
            end
        end
        issue_valid = 1'b0;
        t = 0;
        while (cdb_q.size() < nc + 3 && t < 40) begin
            step();
            t++;
        end
        chk("b2b_accepts", acc_q.size() - k, 3);
        chk("b2b_cdb_count", cdb_q.size() - nc, 3);
        if (acc_q.size() >= k + 3) begin
            chk("b2b_spacing01", acc_q[k+1] - acc_q[k], 4);
            chk("b2b_spacing12", acc_q[k+2] - acc_q[k+1], 4);
        end
        for (int n = 0; n < 3; n++) begin
            if (cdb_q.size() > nc + n) begin
                chk($sformatf("b2b%0d_rob", n), {27'h0, cdb_q[nc+n].rob}, 32'(1 + n));
                chk($sformatf("b2b%0d_data", n), cdb_q[nc+n].data, 32'h11 * (n + 1));
            end
        end

        // Reset in WAIT: outputs return to reset values, transaction abandoned.
        b = '{ST, 3'b010, 32'h0000_0700, 32'h0, 32'h55AA_55AA, 32'h0, 20, 13, 5,
              32'h0000_0700, 4'h0, 4'hF, 32'h55AA_55AA, 1'b0, 32'h0};
        do_issue(b);
        chk("rst_pre_wdata", dmem_wdata, 32'h55AA_55AA);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_wait");
        nc = cdb_q.size();
        nrsp = resp_count;
        for (int n = 0; n < 8; n++) step();
        chk("rst_wait_no_resp", resp_count, nrsp);
        chk("rst_wait_no_cdb", cdb_q.size(), nc);
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=0x%08h required=0x%08h", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory execution unit at the consumer end of the load/store queue. It accepts one issued load or store entry at a time and reads its source operands from the physical register file. It performs a single data-memory transaction, then broadcasts completion (and load data) on the common data bus (CDB) to the ROB and the register file. Only one memory access is in flight at a time.

## Interface
- NUM_REGS, 64, physical register count; tag width PW = $clog2(NUM_REGS)
- ROB_SIZE, 32, ROB entries; index width RW = $clog2(ROB_SIZE)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush (mispredict); kills the current entry
- issue_valid  in  1  queue presents an entry
- issue_ready  out  1  unit can accept; the queue pops on issue_valid && issue_ready
- issue_opcode  in  7  7'b0000011 load, 7'b0100011 store
- issue_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- issue_imm  in  32  sign-extended offset
- issue_rs1_data, issue_rs2_data  in  32 each  operand values (valid at issue)
- issue_phys_rd  in  PW  destination tag
- issue_rob_index  in  RW  ROB slot
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_rmask, dmem_wmask  out  4 each  byte enables; at most one mask is nonzero
- dmem_wdata  out  32  store data shifted into byte lanes
- dmem_rdata  in  32  load word
- dmem_resp  in  1  transaction complete, single-cycle pulse
- cdb_valid  out  1  completion pulse
- cdb_rd_we  out  1  1 for load with phys_rd != 0, else 0
- cdb_phys_rd  out  PW, cdb_rob_index  out  RW, cdb_data  out  32

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: issue_ready=1. On issue_valid && !flush, capture opcode, funct3, phys_rd, rob_index and rs2_data; compute and register addr = rs1_data + imm (mod 2^32); go to REQ.
- REQ, one cycle: drive dmem_addr and the mask; go to WAIT.
  - Load masks: b 0001<<addr[1:0], h 0011<<addr[1:0], w 1111.
  - Store masks: same lanes as loads, driven on wmask.
  - Store data: dmem_wdata = rs2_data << (8*addr[1:0]).
  - Masks are 0 in all other states.
- WAIT: hold dmem_addr; masks 0. On dmem_resp, register the result and go to DONE.
  - Load result: byte/half extracted at lane addr[1:0], sign- or zero-extended per funct3.
  - Store result: cdb_data = 0.
- DONE, one cycle: cdb_valid=1 with the registered fields; go to IDLE.
- Misaligned accesses (h with addr[0]=1, w with addr[1:0]!=0) are out of scope. Stimulus never produces them.
- Flush handling:
  - IDLE: nothing is accepted that cycle.
  - REQ: no request is issued; go to IDLE.
  - WAIT: set the drop flag and keep waiting. On dmem_resp go to IDLE with no CDB pulse. Flushes already absorbed by the drop flag are ignored.
  - DONE: cdb_valid is forced to 0; go to IDLE.
- Drop flag is cleared on entry to IDLE.
- rst takes priority over everything. rst in WAIT abandons the outstanding transaction; the memory model must also be reset.

## Timing
- Reset values:
  - state IDLE, issue_ready 1
  - dmem_rmask/wmask 0, dmem_addr 0, dmem_wdata 0
  - cdb_valid 0, cdb_rd_we 0, cdb_phys_rd 0, cdb_rob_index 0, cdb_data 0
  - drop flag 0
- Accept at edge N → request visible in cycle N+1 → earliest dmem_resp in cycle N+2.
- dmem_resp at edge M → cdb_valid high in cycle M+1, for exactly one cycle → issue_ready high in cycle M+2.
- Minimum issue-to-issue spacing with a 1-cycle memory: 4 cycles.
- issue_ready is 0 in REQ, WAIT and DONE. The queue must not pop then.
- dmem_resp outside WAIT is ignored.

## Test plan
- Word load: rs1=0x1000, imm=4, rdata=0xDEADBEEF, phys_rd=5, rob=3 → dmem_addr=0x1004, rmask=1111, one cycle; then cdb_valid, rd_we=1, data=0xDEADBEEF, phys_rd=5, rob=3.
- Byte loads: rs1=0x2003, imm=0, rdata=0x80FF_FFFF, lb → rmask=1000, cdb_data=0xFFFFFF80. Same access with lbu → 0x00000080.
- Halfword store: rs1=0x3000, imm=2, rs2=0x1234ABCD, sh → wmask=1100, wdata=0xABCD0000; cdb_valid with rd_we=0, data=0.
- Load to x0: phys_rd=0 → cdb_valid=1 with cdb_rd_we=0.
- Flush in WAIT, response delayed 3 cycles → no cdb_valid; issue_ready returns the cycle after dmem_resp. Flush in REQ → masks never asserted.
- Back-to-back issue_valid held high for 3 entries → exactly 3 accepts, 3 CDB pulses in order. rst mid-WAIT → all outputs return to reset values the next cycle.
